// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings, reset defaults,
// fetch FSM state type and the wrapping pc+4 helper.
package if_fetch_stage_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_J   = 2'b10;
   localparam logic [1:0] PCSRC_JR  = 2'b11;

   localparam logic [XLEN-1:0] NOP_INST_DFLT = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_PC_DFLT = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      VALID = 1'b1
   } fetch_state_e;

   // Sequential successor, modulo 2^32
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return XLEN'(pc + XLEN'(4));
   endfunction

endpackage

// File: rtl/if_fetch_stage_next_pc_sel.sv
// Combinational next-PC mux: pending redirect beats the live pcsrc select,
// which beats the sequential pc+4.
module if_fetch_stage_next_pc_sel
   import if_fetch_stage_pkg::*;
(
   input  logic [XLEN-1:0] i_pc,
   input  logic [1:0]      i_pcsrc,
   input  logic [XLEN-1:0] i_bpc,
   input  logic [XLEN-1:0] i_jpc,
   input  logic [XLEN-1:0] i_rpc,
   input  logic            i_pend,
   input  logic [XLEN-1:0] i_pend_target,
   output logic [XLEN-1:0] o_sel_target_c,
   output logic [XLEN-1:0] o_npc_c
);

   // Target selection and redirect priority
   always_comb begin
      o_sel_target_c = i_bpc;
      case (i_pcsrc)
         PCSRC_J:  o_sel_target_c = i_jpc;
         PCSRC_JR: o_sel_target_c = i_rpc;
         default:  o_sel_target_c = i_bpc;
      endcase

      o_npc_c = pc_plus4(i_pc);
      if (i_pend) begin
         o_npc_c = i_pend_target;
      end else if (i_pcsrc != PCSRC_SEQ) begin
         o_npc_c = o_sel_target_c;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding IF/ID. Owns the PC, runs a FETCH/VALID
// handshake with a variable-latency instruction memory, and remembers a
// redirect seen while a fetch is outstanding so the delay slot still issues.
// Optional: define IMEM_TIMEOUT_EN to add a fetch-wait watchdog and if_err.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DFLT,
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DFLT
`ifdef IMEM_TIMEOUT_EN
   ,
   parameter logic [7:0]      TIMEOUT  = 8'd64
`endif
)(
   input  logic            clk,
   input  logic            clr,
   input  logic            stall,
   input  logic [1:0]      pcsrc,
   input  logic [XLEN-1:0] bpc,
   input  logic [XLEN-1:0] jpc,
   input  logic [XLEN-1:0] rpc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] if_pc4,
   output logic [XLEN-1:0] if_inst,
   output logic            if_valid
`ifdef IMEM_TIMEOUT_EN
   ,
   output logic            if_err
`endif
);

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_inst_buf;
   logic            r_pend;
   logic [XLEN-1:0] r_pend_target;
   logic            r_imem_req;
   logic            r_if_valid;
   logic [XLEN-1:0] r_if_pc4;
   logic [XLEN-1:0] w_sel_target;
   logic [XLEN-1:0] w_npc;
`ifdef IMEM_TIMEOUT_EN
   logic [7:0]      r_wait_cnt;
   logic            r_err;
`endif

   if_fetch_stage_next_pc_sel u_next_pc_sel (
      .i_pc           (r_pc),
      .i_pcsrc        (pcsrc),
      .i_bpc          (bpc),
      .i_jpc          (jpc),
      .i_rpc          (rpc),
      .i_pend         (r_pend),
      .i_pend_target  (r_pend_target),
      .o_sel_target_c (w_sel_target),
      .o_npc_c        (w_npc)
   );

   // Fetch FSM, PC register, redirect latch and registered IF/ID outputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state       <= FETCH;
         r_pc          <= RESET_PC;
         r_inst_buf    <= NOP_INST;
         r_pend        <= 1'b0;
         r_pend_target <= RESET_PC;
         r_imem_req    <= 1'b1;
         r_if_valid    <= 1'b0;
         r_if_pc4      <= pc_plus4(RESET_PC);
`ifdef IMEM_TIMEOUT_EN
         r_wait_cnt    <= 8'd0;
         r_err         <= 1'b0;
`endif
      end else begin
         case (r_state)
            FETCH: begin
               if (!stall && (pcsrc != PCSRC_SEQ)) begin
                  r_pend        <= 1'b1;
                  r_pend_target <= w_sel_target;
               end
               if (imem_ready) begin
                  r_inst_buf <= imem_rdata;
                  r_state    <= VALID;
                  r_imem_req <= 1'b0;
                  r_if_valid <= 1'b1;
`ifdef IMEM_TIMEOUT_EN
                  r_wait_cnt <= 8'd0;
               end else if (r_wait_cnt == 8'(TIMEOUT - 8'd1)) begin
                  r_err      <= 1'b1;
                  r_inst_buf <= NOP_INST;
                  r_state    <= VALID;
                  r_imem_req <= 1'b0;
                  r_if_valid <= 1'b1;
                  r_wait_cnt <= 8'd0;
               end else begin
                  r_wait_cnt <= 8'(r_wait_cnt + 8'd1);
`endif
               end
            end
            VALID: begin
               if (!stall) begin
                  r_pc       <= w_npc;
                  r_pend     <= 1'b0;
                  r_state    <= FETCH;
                  r_inst_buf <= NOP_INST;
                  r_imem_req <= 1'b1;
                  r_if_valid <= 1'b0;
                  r_if_pc4   <= pc_plus4(w_npc);
               end
            end
         endcase
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_pc;
   assign if_inst   = r_inst_buf;
   assign if_valid  = r_if_valid;
   assign if_pc4    = r_if_pc4;
`ifdef IMEM_TIMEOUT_EN
   assign if_err    = r_err;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized pcsrc/stall/
// memory-latency traffic, checked against a transaction-level model of the
// PC stream (which instruction is presented and where the next fetch goes).
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  pcsrc = 2'b00;
   logic [31:0] bpc = '0, jpc = '0, rpc = '0;
   logic        imem_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr, imem_rdata, if_pc4, if_inst;
   logic        if_valid;

   logic        tie0 = 1'b0, tie1 = 1'b1;
   logic [1:0]  tie00 = 2'b00;
   logic [31:0] tiez = '0;

   logic        wr_req, wr_valid;
   logic [31:0] wr_addr, wr_rdata, wr_pc4, wr_inst;
`ifdef IMEM_TIMEOUT_EN
   logic        if_err, wr_err, to_err, to_req, to_valid;
   logic [31:0] to_addr, to_rdata, to_pc4, to_inst;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction model state
   logic [31:0] m_pc, m_tgt;
   bit          m_have, m_pend;
   int          m_wait;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return 32'((a * 32'h9E37_79B9) ^ 32'h1234_5678);
   endfunction

   assign imem_rdata = mem_fn(imem_addr);
   assign wr_rdata   = mem_fn(wr_addr);

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk(clk), .clr(clr), .stall(stall), .pcsrc(pcsrc),
      .bpc(bpc), .jpc(jpc), .rpc(rpc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_pc4(if_pc4), .if_inst(if_inst), .if_valid(if_valid)
`ifdef IMEM_TIMEOUT_EN
      , .if_err(if_err)
`endif
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .clr(clr), .stall(tie0), .pcsrc(tie00),
      .bpc(tiez), .jpc(tiez), .rpc(tiez),
      .imem_req(wr_req), .imem_addr(wr_addr),
      .imem_ready(tie1), .imem_rdata(wr_rdata),
      .if_pc4(wr_pc4), .if_inst(wr_inst), .if_valid(wr_valid)
`ifdef IMEM_TIMEOUT_EN
      , .if_err(wr_err)
`endif
   );

`ifdef IMEM_TIMEOUT_EN
   assign to_rdata = mem_fn(to_addr);
   if_fetch_stage #(.TIMEOUT(8'd4)) u_tmo (
      .clk(clk), .clr(clr), .stall(tie0), .pcsrc(tie00),
      .bpc(tiez), .jpc(tiez), .rpc(tiez),
      .imem_req(to_req), .imem_addr(to_addr),
      .imem_ready(tie0), .imem_rdata(to_rdata),
      .if_pc4(to_pc4), .if_inst(to_inst), .if_valid(to_valid),
      .if_err(to_err)
   );
`endif

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input logic [31:0] rst_pc);
      m_pc = rst_pc; m_have = 0; m_pend = 0; m_wait = 0;
   endtask

   // Compare presented outputs with what the model says should be on IF/ID now
   task automatic check_model();
      check32("addr",  imem_addr, m_pc);
      check32("pc4",   if_pc4, 32'(m_pc + 32'd4));
      check32("req",   32'(imem_req), m_have ? 32'd0 : 32'd1);
      check32("valid", 32'(if_valid), 32'(m_have));
      check32("inst",  if_inst, m_have ? mem_fn(m_pc) : NOP);
   endtask

   // One clock: check, drive inputs, predict the effect, move to next negedge
   task automatic step(input logic st, input logic [1:0] ps, input logic [31:0] bt,
                       input logic [31:0] jt, input logic [31:0] rt, input logic rdy);
      logic [31:0] tgt;
      check_model();
      stall = st; pcsrc = ps; bpc = bt; jpc = jt; rpc = rt; imem_ready = rdy;
      case (ps)
         2'b01:   tgt = bt;
         2'b10:   tgt = jt;
         default: tgt = rt;
      endcase
      if (!m_have) begin
         if (!st && ps != 2'b00) begin m_pend = 1; m_tgt = tgt; end
         if (rdy) begin m_have = 1; m_wait = 0; end
         else m_wait++;
      end else if (!st) begin
         m_pc   = m_pend ? m_tgt : (ps != 2'b00 ? tgt : 32'(m_pc + 32'd4));
         m_pend = 0;
         m_have = 0;
      end
      @(negedge clk);
   endtask

   // Zero-latency fetch followed by sequential advance, n times
   task automatic adv(input int n);
      repeat (n) begin
         step(1'b0, 2'b00, '0, '0, '0, 1'b1);
         step(1'b0, 2'b00, '0, '0, '0, 1'b1);
      end
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      // Reset values while clr is held
      check32("rst_valid", 32'(if_valid), 32'd0);
      check32("rst_inst",  if_inst, NOP);
      check32("rst_pc4",   if_pc4, 32'd4);
      check32("rst_addr",  imem_addr, 32'd0);
      check32("rst_req",   32'(imem_req), 32'd1);
      check32("rst_wr_pc4", wr_pc4, 32'd0);
      clr = 1'b0;
      model_reset(32'd0);

      // Zero-latency memory: addr 0,0,4,4,8,8; plus wrap and watchdog instances
      for (int i = 0; i < 6; i++) begin
         check32("zl_addr", imem_addr, 32'((i / 2) * 4));
         if (i == 0) begin
            check32("wrap_addr0", wr_addr, 32'hFFFF_FFFC);
            check32("wrap_pc4_0", wr_pc4, 32'd0);
         end
         if (i == 1) begin
            check32("wrap_valid", 32'(wr_valid), 32'd1);
            check32("wrap_inst",  wr_inst, mem_fn(32'hFFFF_FFFC));
            check32("wrap_pc4_1", wr_pc4, 32'd0);
         end
         if (i == 2) check32("wrap_next", wr_addr, 32'd0);
`ifdef IMEM_TIMEOUT_EN
         if (i == 0) check32("tmo_err0", 32'(to_err), 32'd0);
         if (i == 4) begin
            check32("tmo_err",   32'(to_err), 32'd1);
            check32("tmo_valid", 32'(to_valid), 32'd1);
            check32("tmo_inst",  to_inst, NOP);
         end
         if (i == 5) check32("tmo_adv", to_addr, 32'd4);
`endif
         step(1'b0, 2'b00, '0, '0, '0, 1'b1);
      end
      check32("zl_next", imem_addr, 32'h0C);

      // 3-cycle memory latency at 0x10
      adv(1);
      for (int i = 0; i < 3; i++) begin
         check32("lat_req",   32'(imem_req), 32'd1);
         check32("lat_valid", 32'(if_valid), 32'd0);
         step(1'b0, 2'b00, '0, '0, '0, (i == 2) ? 1'b1 : 1'b0);
      end
      check32("lat_inst", if_inst, mem_fn(32'h10));
      check32("lat_pc4",  if_pc4, 32'h14);
      step(1'b0, 2'b00, '0, '0, '0, 1'b0);

      // Stall held in VALID at 0x20
      adv(3);
      step(1'b0, 2'b00, '0, '0, '0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check32("stall_inst", if_inst, mem_fn(32'h20));
         check32("stall_pc4",  if_pc4, 32'h24);
         check32("stall_req",  32'(imem_req), 32'd0);
         step(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      step(1'b0, 2'b00, '0, '0, '0, 1'b0);
      check32("stall_next", imem_addr, 32'h24);

      // Branch taken from VALID at 0x30
      adv(3);
      step(1'b0, 2'b00, '0, '0, '0, 1'b1);
      step(1'b0, 2'b01, 32'h100, '0, '0, 1'b0);
      check32("br_addr", imem_addr, 32'h100);

      // Jump captured mid-fetch at 0x44: delay slot issues, then 0x200
      step(1'b0, 2'b00, '0, '0, '0, 1'b1);
      step(1'b0, 2'b11, '0, '0, 32'h44, 1'b0);
      check32("jr_addr", imem_addr, 32'h44);
      step(1'b0, 2'b10, '0, 32'h200, '0, 1'b0);
      step(1'b0, 2'b00, '0, '0, '0, 1'b0);
      step(1'b0, 2'b00, '0, '0, '0, 1'b1);
      check32("ds_inst", if_inst, mem_fn(32'h44));
      check32("ds_pc4",  if_pc4, 32'h48);
      step(1'b0, 2'b00, '0, '0, '0, 1'b0);
      check32("ds_next", imem_addr, 32'h200);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic       st, rdy;
         logic [1:0] ps;
         st  = ($urandom_range(0, 3) == 0);
         ps  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rdy = ($urandom_range(0, 1) == 1) || (m_wait >= 20);
         step(st, ps, $urandom, $urandom, $urandom, rdy);
      end

      // Reset while a fetch (with pending redirect) is outstanding
      if (m_have) step(1'b0, 2'b00, '0, '0, '0, 1'b0);
      step(1'b0, 2'b01, 32'h500, '0, '0, 1'b0);
      #7 clr = 1'b1;
      #1;
      check32("mr_addr",  imem_addr, 32'd0);
      check32("mr_valid", 32'(if_valid), 32'd0);
      check32("mr_inst",  if_inst, NOP);
      @(negedge clk);
      clr = 1'b0;
      model_reset(32'd0);
      step(1'b0, 2'b00, '0, '0, '0, 1'b1);
      step(1'b0, 2'b00, '0, '0, '0, 1'b0);
      check32("mr_next", imem_addr, 32'd4);
`ifdef IMEM_TIMEOUT_EN
      check32("main_err", 32'(if_err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
